uart_tx: RTL

UART transmitter for the axis_uart core: accepts 9-bit words on an AXI-Stream slave and serialises each one onto `txd` as start bit, data bits, optional parity and stop bits. Frame format and baud rate are set at reset from parameters and can be changed at run time through a config stream. This block is the transmit-side counterpart of the UART receiver and uses the same config word layout. It sits between the TX FIFO (upstream) and the `txd` pad.

---
 rtl/uart_pkg.sv | 75 +++++++
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx_baud.sv | 19 +
 rtl/uart_tx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, field positions and helper functions for the axis_uart transmit path.
// The config word layout matches the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_STOP2
  } tx_state_t;

  localparam logic [2:0] PARITY_NONE  = 3'd0;
  localparam logic [2:0] PARITY_EVEN  = 3'd1;
  localparam logic [2:0] PARITY_ODD   = 3'd2;
  localparam logic [2:0] PARITY_MARK  = 3'd3;
  localparam logic [2:0] PARITY_SPACE = 3'd4;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam int CFG_W          = 27;
  localparam int CFG_PRESC_LSB  = 0;
  localparam int CFG_PRESC_W    = 16;
  localparam int CFG_PARITY_LSB = 16;
  localparam int CFG_PARITY_W   = 3;
  localparam int CFG_BYTES_LSB  = 19;
  localparam int CFG_BYTES_W    = 4;
  localparam int CFG_STOP_BIT   = 23;
  localparam int CFG_ENABLE_BIT = 24;

  localparam logic [3:0]  BYTE_SIZE_MIN = 4'd5;
  localparam logic [3:0]  BYTE_SIZE_MAX = 4'd9;
  localparam logic [15:0] PRESCALER_MIN = 16'd2;

  typedef struct packed {
    logic [15:0] prescaler;
    logic [2:0]  parity;
    logic [3:0]  byte_size;
    logic        stop_bits;
    logic        enable;
  } tx_cfg_t;

  // Out-of-range fields are folded to the nearest legal setting rather than rejected.
  function automatic tx_cfg_t clamp_cfg(input logic [15:0] pres, input logic [2:0] par,
                                        input logic [3:0] bs, input logic stop, input logic en);
    tx_cfg_t c;
    c.prescaler = (pres < PRESCALER_MIN) ? PRESCALER_MIN : pres;
    c.parity    = (par > PARITY_SPACE) ? PARITY_NONE : par;
    c.byte_size = (bs < BYTE_SIZE_MIN) ? BYTE_SIZE_MIN :
                  (bs > BYTE_SIZE_MAX) ? BYTE_SIZE_MAX : bs;
    c.stop_bits = stop;
    c.enable    = en;
    return c;
  endfunction

  function automatic logic frame_parity(input logic [8:0] data, input logic [3:0] bs,
                                        input logic [2:0] par);
    logic x;
    logic p;
    x = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < int'(bs)) x = x ^ data[i];
    end
    case (par)
      PARITY_EVEN: p = x;
      PARITY_ODD:  p = ~x;
      PARITY_MARK: p = 1'b1;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Config and data AXI-Stream slave channels of the UART transmitter.
// Both channels: a word transfers in a cycle where tvalid and tready are both high at the
// rising aclk edge; tdata is only meaningful while tvalid is high.
interface uart_tx_if;
  import uart_pkg::*;

  logic [CFG_W-1:0] s_axis_config_tdata;
  logic             s_axis_config_tvalid;
  logic             s_axis_config_tready;
  logic [8:0]       s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;

  modport master (
    output s_axis_config_tdata, s_axis_config_tvalid, s_axis_tdata, s_axis_tvalid,
    input  s_axis_config_tready, s_axis_tready
  );

  modport slave (
    input  s_axis_config_tdata, s_axis_config_tvalid, s_axis_tdata, s_axis_tvalid,
    output s_axis_config_tready, s_axis_tready
  );
endinterface

// File: rtl/uart_tx_baud.sv
// Bit-period timer: stb marks the last cycle of every div-cycle period while enabled.
module uart_tx_baud (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        en,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        stb
);
  logic [15:0] cnt;

  assign stb = en & (cnt == div - 16'd1);

  always_ff @(posedge aclk) begin
    if (!aresetn)            cnt <= '0;
    else if (restart || stb) cnt <= '0;
    else if (en)             cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises AXI-Stream words onto txd with a run-time configurable
// frame format; the format is captured per frame so config updates never disturb the line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_PRESCALER = 12,
  parameter int PARITY         = 0,
  parameter int BYTE_SIZE      = 8,
  parameter int STOP_BITS      = 0
) (
  input  logic      aclk,
  input  logic      aresetn,
  uart_tx_if.slave  axis,
  output logic      txd,
  input  logic      ctsn,
  output logic      busy,
  output tx_state_t dbg_state
);
  localparam tx_cfg_t CFG_RESET = clamp_cfg(16'(BAUD_PRESCALER), 3'(PARITY), 4'(BYTE_SIZE),
                                            1'(STOP_BITS), 1'b1);

  tx_cfg_t     cfg;
  tx_state_t   state, state_n;
  logic [3:0]  bit_idx, bit_idx_n;
  logic [8:0]  data_q;
  logic        par_q;
  logic [3:0]  f_bytes;
  logic        f_par_en;
  logic        f_two_stop;
  logic [15:0] f_div;
  logic        ctsn_s1, ctsn_s2, cts;
  logic        stb, cfg_fire, data_fire, final_stop, txd_n;

  assign axis.s_axis_config_tready = (state == ST_IDLE);
  assign cfg_fire   = axis.s_axis_config_tvalid & axis.s_axis_config_tready;
  assign final_stop = ((state == ST_STOP) & ~f_two_stop) | (state == ST_STOP2);
  assign axis.s_axis_tready = cfg.enable & cts & ~cfg_fire &
                              ((state == ST_IDLE) | (final_stop & stb));
  assign data_fire  = axis.s_axis_tvalid & axis.s_axis_tready;
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

  always_ff @(posedge aclk) begin
    if (!aresetn) cfg <= CFG_RESET;
    else if (cfg_fire)
      cfg <= clamp_cfg(axis.s_axis_config_tdata[CFG_PRESC_LSB +: CFG_PRESC_W],
                       axis.s_axis_config_tdata[CFG_PARITY_LSB +: CFG_PARITY_W],
                       axis.s_axis_config_tdata[CFG_BYTES_LSB +: CFG_BYTES_W],
                       axis.s_axis_config_tdata[CFG_STOP_BIT],
                       axis.s_axis_config_tdata[CFG_ENABLE_BIT]);
  end

  // ctsn is asynchronous; the third flop registers the comparison that gates acceptance.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ctsn_s1 <= 1'b1;
      ctsn_s2 <= 1'b1;
      cts     <= 1'b0;
    end else begin
      ctsn_s1 <= ctsn;
      ctsn_s2 <= ctsn_s1;
      cts     <= ~ctsn_s2;
    end
  end

  uart_tx_baud u_baud (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (state != ST_IDLE),
    .restart (data_fire),
    .div     (f_div),
    .stb     (stb)
  );

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    case (state)
      ST_IDLE:  if (data_fire) state_n = ST_START;
      ST_START: if (stb) begin
        state_n   = ST_DATA;
        bit_idx_n = '0;
      end
      ST_DATA:  if (stb) begin
        if (bit_idx == f_bytes - 4'd1) state_n = f_par_en ? ST_PAR : ST_STOP;
        else                           bit_idx_n = bit_idx + 4'd1;
      end
      ST_PAR:   if (stb) state_n = ST_STOP;
      ST_STOP:  if (stb) state_n = f_two_stop ? ST_STOP2 : (data_fire ? ST_START : ST_IDLE);
      ST_STOP2: if (stb) state_n = data_fire ? ST_START : ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    // txd is the IOB register, so it is loaded with the level of the state being entered.
    case (state_n)
      ST_START: txd_n = 1'b0;
      ST_DATA:  txd_n = data_q[bit_idx_n];
      ST_PAR:   txd_n = par_q;
      default:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      bit_idx <= bit_idx_n;
      txd     <= txd_n;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_q     <= '0;
      par_q      <= 1'b0;
      f_bytes    <= CFG_RESET.byte_size;
      f_par_en   <= 1'b0;
      f_two_stop <= STOP_ONE;
      f_div      <= CFG_RESET.prescaler;
    end else if (data_fire) begin
      data_q     <= axis.s_axis_tdata;
      par_q      <= frame_parity(axis.s_axis_tdata, cfg.byte_size, cfg.parity);
      f_bytes    <= cfg.byte_size;
      f_par_en   <= (cfg.parity != PARITY_NONE);
      f_two_stop <= cfg.stop_bits;
      f_div      <= cfg.prescaler;
    end
  end
endmodule
